// File: rtl/flop_regfile_2r1w.sv
// Flip-flop register file with one write port and two registered read ports.
// Each entry carries a valid bit. A single entry can be invalidated, and a flush
// pulse starts a sweep that clears every valid bit, one entry per cycle.
//
// Ports:
//   i_clk, i_resetn            clock, asynchronous active-low reset
//   i_wr, i_waddr, i_din       write request, address, data
//   i_inv, i_iaddr             single-entry invalidate request, address
//   i_flush                    pulse that starts a whole-array sweep
//   i_rdN, i_raddrN            read request and address, port N (N = 0, 1)
//   o_doutN, o_dout_vN, o_errN read data, valid and error, one cycle after i_rdN
//   o_wr_err                   write or invalidate was dropped (one-cycle pulse)
//   o_busy                     flush sweep in progress
module flop_regfile_2r1w #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_N = 8,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_inv,
  input  logic [ADDR_W-1:0] i_iaddr,
  input  logic              i_flush,
  input  logic              i_rd0,
  input  logic [ADDR_W-1:0] i_raddr0,
  input  logic              i_rd1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_dout0,
  output logic              o_dout_v0,
  output logic              o_err0,
  output logic [DATA_W-1:0] o_dout1,
  output logic              o_dout_v1,
  output logic              o_err1,
  output logic              o_wr_err,
  output logic              o_busy
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  logic [DATA_W-1:0] r_data [DATA_N];
  logic [DATA_N-1:0] r_valid, w_valid_d;
  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_cnt, w_cnt_d;

  logic              w_busy;
  logic              w_wr_ok, w_inv_ok, w_wr_drop, w_inv_drop, w_last;

  logic              w_rd     [2];
  logic [ADDR_W-1:0] w_raddr  [2];
  logic              w_good   [2];
  logic [DATA_W-1:0] w_rdata  [2];

  logic [DATA_W-1:0] r_dout   [2];
  logic              r_dout_v [2];
  logic              r_err    [2];
  logic              r_wr_err;

  assign w_busy     = (r_state == StSweep);
  assign w_wr_ok    = i_wr & ~w_busy & (32'(i_waddr) < DATA_N);
  assign w_inv_ok   = i_inv & ~w_busy & (32'(i_iaddr) < DATA_N);
  assign w_wr_drop  = i_wr & ~w_wr_ok;
  assign w_inv_drop = i_inv & ~w_inv_ok;
  assign w_last     = (32'(r_cnt) == DATA_N - 1);

  assign w_rd[0]    = i_rd0;
  assign w_rd[1]    = i_rd1;
  assign w_raddr[0] = i_raddr0;
  assign w_raddr[1] = i_raddr1;

  // Next-state for the valid bits and the flush sweep. In the idle state the
  // write is applied after the invalidate, so a write to the same entry wins.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_valid_d = r_valid;
    unique case (r_state)
      StIdle: begin
        if (w_inv_ok) w_valid_d[i_iaddr] = 1'b0;
        if (w_wr_ok)  w_valid_d[i_waddr] = 1'b1;
        if (i_flush) begin
          w_state_d = StSweep;
          w_cnt_d   = '0;
        end
      end
      StSweep: begin
        w_valid_d[r_cnt] = 1'b0;
        if (w_last) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Read lookup. A bypass hit can only occur when the write is accepted, which
  // already implies the array is not busy and the address is in range.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_good[p]  = 1'b0;
      w_rdata[p] = '0;
      if (BYPASS && w_wr_ok && (i_waddr == w_raddr[p])) begin
        w_good[p]  = 1'b1;
        w_rdata[p] = i_din;
      end else if ((32'(w_raddr[p]) < DATA_N) && !w_busy) begin
        w_good[p]  = r_valid[w_raddr[p]];
        w_rdata[p] = r_data[w_raddr[p]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_valid  <= '0;
      r_wr_err <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        r_dout[p]   <= '0;
        r_dout_v[p] <= 1'b0;
        r_err[p]    <= 1'b0;
      end
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_valid  <= w_valid_d;
      r_wr_err <= w_wr_drop | w_inv_drop;
      for (int p = 0; p < 2; p++) begin
        r_dout_v[p] <= w_rd[p];
        r_err[p]    <= w_rd[p] & ~w_good[p];
        r_dout[p]   <= (w_rd[p] && w_good[p]) ? w_rdata[p] : '0;
      end
    end
  end

  // Data storage is deliberately left unreset; the valid bits gate every read.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_data[i_waddr] <= i_din;
  end

  assign o_dout0   = r_dout[0];
  assign o_dout_v0 = r_dout_v[0];
  assign o_err0    = r_err[0];
  assign o_dout1   = r_dout[1];
  assign o_dout_v1 = r_dout_v[1];
  assign o_err1    = r_err[1];
  assign o_wr_err  = r_wr_err;
  assign o_busy    = w_busy;

endmodule

// File: tb/tb_flop_regfile_2r1w.sv
// Bench for flop_regfile_2r1w. Two instances share one stimulus stream:
// instance A uses the defaults (8 entries, bypass on), instance B has 6 entries
// and bypass off. A behavioural model predicts every output of both instances.
module tb_flop_regfile_2r1w;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       wr = 1'b0, inv = 1'b0, flush = 1'b0, rd0 = 1'b0, rd1 = 1'b0;
  logic [2:0] waddr = '0, iaddr = '0, raddr0 = '0, raddr1 = '0;
  logic [7:0] din = '0;

  logic [7:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic       a_v0, a_err0, a_v1, a_err1, a_wr_err, a_busy;
  logic       b_v0, b_err0, b_v1, b_err1, b_wr_err, b_busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flop_regfile_2r1w #(.DATA_W(8), .ADDR_W(3), .DATA_N(8), .BYPASS(1'b1)) u_a (
    .i_clk(clk), .i_resetn(resetn), .i_wr(wr), .i_waddr(waddr), .i_din(din),
    .i_inv(inv), .i_iaddr(iaddr), .i_flush(flush),
    .i_rd0(rd0), .i_raddr0(raddr0), .i_rd1(rd1), .i_raddr1(raddr1),
    .o_dout0(a_dout0), .o_dout_v0(a_v0), .o_err0(a_err0),
    .o_dout1(a_dout1), .o_dout_v1(a_v1), .o_err1(a_err1),
    .o_wr_err(a_wr_err), .o_busy(a_busy)
  );

  flop_regfile_2r1w #(.DATA_W(8), .ADDR_W(3), .DATA_N(6), .BYPASS(1'b0)) u_b (
    .i_clk(clk), .i_resetn(resetn), .i_wr(wr), .i_waddr(waddr), .i_din(din),
    .i_inv(inv), .i_iaddr(iaddr), .i_flush(flush),
    .i_rd0(rd0), .i_raddr0(raddr0), .i_rd1(rd1), .i_raddr1(raddr1),
    .o_dout0(b_dout0), .o_dout_v0(b_v0), .o_err0(b_err0),
    .o_dout1(b_dout1), .o_dout_v1(b_v1), .o_err1(b_err1),
    .o_wr_err(b_wr_err), .o_busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_data  [2][8];
  bit         m_valid [2][8];
  bit         m_busy  [2];
  int         m_left  [2];   // sweep cycles still to run
  logic [7:0] e_dout  [2][2];
  bit         e_v     [2][2];
  bit         e_err   [2][2];
  bit         e_wr_err[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0;
      m_left[k] = 0;
      e_wr_err[k] = 0;
      for (int i = 0; i < 8; i++) m_valid[k][i] = 0;
      for (int p = 0; p < 2; p++) begin
        e_dout[k][p] = '0; e_v[k][p] = 0; e_err[k][p] = 0;
      end
    end
  endtask

  task automatic model_edge(input int k);
    int n;
    bit byp, wok, iok, rq;
    logic [2:0] ra;
    n   = (k == 0) ? 8 : 6;
    byp = (k == 0);
    wok = wr && !m_busy[k] && (int'(waddr) < n);
    iok = inv && !m_busy[k] && (int'(iaddr) < n);
    for (int p = 0; p < 2; p++) begin
      rq = (p == 0) ? rd0 : rd1;
      ra = (p == 0) ? raddr0 : raddr1;
      e_v[k][p] = rq;
      e_err[k][p] = 0;
      e_dout[k][p] = '0;
      if (rq) begin
        if (byp && wok && waddr == ra)                         e_dout[k][p] = din;
        else if (int'(ra) >= n || m_busy[k] || !m_valid[k][ra]) e_err[k][p] = 1;
        else                                                    e_dout[k][p] = m_data[k][ra];
      end
    end
    e_wr_err[k] = (wr && !wok) || (inv && !iok);
    if (m_busy[k]) begin
      m_valid[k][n - m_left[k]] = 0;
      m_left[k]--;
      if (m_left[k] == 0) m_busy[k] = 0;
    end else begin
      if (iok) m_valid[k][iaddr] = 0;
      if (wok) begin
        m_data[k][waddr] = din;
        m_valid[k][waddr] = 1;
      end
      if (flush) begin
        m_busy[k] = 1;
        m_left[k] = n;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else begin
        model_edge(0);
        model_edge(1);
      end
    end
  end

  task automatic cmp_inst(input string t, input int k, input logic [7:0] d0, input logic v0,
                          input logic er0, input logic [7:0] d1, input logic v1, input logic er1,
                          input logic we, input logic bz);
    chk({t, "_dout0"}, d0, e_dout[k][0]);
    chk({t, "_dout_v0"}, v0, e_v[k][0]);
    chk({t, "_err0"}, er0, e_err[k][0]);
    chk({t, "_dout1"}, d1, e_dout[k][1]);
    chk({t, "_dout_v1"}, v1, e_v[k][1]);
    chk({t, "_err1"}, er1, e_err[k][1]);
    chk({t, "_wr_err"}, we, e_wr_err[k]);
    chk({t, "_busy"}, bz, m_busy[k]);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cmp_inst("a", 0, a_dout0, a_v0, a_err0, a_dout1, a_v1, a_err1, a_wr_err, a_busy);
      cmp_inst("b", 1, b_dout0, b_v0, b_err0, b_dout1, b_v1, b_err1, b_wr_err, b_busy);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic w, input logic [2:0] wa, input logic [7:0] d,
                      input logic iv, input logic [2:0] ia, input logic fl,
                      input logic r0, input logic [2:0] a0, input logic r1, input logic [2:0] a1);
    wr = w; waddr = wa; din = d; inv = iv; iaddr = ia; flush = fl;
    rd0 = r0; raddr0 = a0; rd1 = r1; raddr1 = a1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int ca, cb;

  initial begin
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", a_busy, 0);
    chk("reset_dout_v0", a_v0, 0);
    resetn = 1'b1;

    // Read of an unwritten entry on both ports.
    step(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
    chk("rd3_v0", a_v0, 1);   chk("rd3_err0", a_err0, 1); chk("rd3_dout0", a_dout0, 0);
    chk("rd3_v1", a_v1, 1);   chk("rd3_err1", a_err1, 1); chk("rd3_dout1", a_dout1, 0);

    // Write then read written and unwritten entries together.
    step(1, 2, 8'hA5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2, 1, 5);
    chk("rd2_dout0", a_dout0, 8'hA5); chk("rd2_err0", a_err0, 0);
    chk("rd5_err1", a_err1, 1);       chk("rd5_dout1", a_dout1, 0);
    chk("b_rd5_err1", b_err1, 1);

    // Both ports on one address.
    step(0, 0, 0, 0, 0, 0, 1, 2, 1, 2);
    chk("same_dout0", a_dout0, 8'hA5); chk("same_dout1", a_dout1, 8'hA5);

    // Read-during-write: bypass on A, old (invalid) contents on B.
    step(1, 4, 8'h3C, 0, 0, 0, 1, 4, 0, 0);
    chk("byp_dout0", a_dout0, 8'h3C); chk("byp_err0", a_err0, 0);
    chk("nobyp_err0", b_err0, 1);     chk("nobyp_dout0", b_dout0, 0);

    // Out-of-range write on B (6 entries), in range on A.
    step(1, 7, 8'h11, 0, 0, 0, 0, 0, 0, 0);
    chk("a_wr7_err", a_wr_err, 0); chk("b_wr7_err", b_wr_err, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("a_rd7_dout1", a_dout1, 8'h11); chk("b_rd7_err1", b_err1, 1);
    chk("wr_err_pulse", b_wr_err, 0);

    // Write and invalidate to the same entry: write wins.
    step(1, 1, 8'h5A, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("wrinv_dout0", a_dout0, 8'h5A); chk("wrinv_err0", a_err0, 0);
    chk("b_wrinv_dout0", b_dout0, 8'h5A);

    // Read-during-invalidate sees the old state; the following read does not.
    step(0, 0, 0, 1, 4, 0, 1, 4, 0, 0);
    chk("rdinv_dout0", a_dout0, 8'h3C); chk("b_rdinv_dout0", b_dout0, 8'h3C);
    step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    chk("postinv_err0", a_err0, 1);

    // Out-of-range invalidate on B.
    step(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    chk("b_inv6_err", b_wr_err, 1); chk("a_inv6_err", a_wr_err, 0);

    // Fill, then flush with a simultaneous write; count busy cycles.
    for (int i = 0; i < 8; i++) step(1, 3'(i), 8'(8'h10 + i), 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 8'hEE, 0, 0, 1, 0, 0, 0, 0);
    ca = int'(a_busy); cb = int'(b_busy);
    chk("flush_busy", a_busy, 1);
    step(1, 3, 8'h77, 0, 0, 1, 1, 5, 0, 0);
    ca += int'(a_busy); cb += int'(b_busy);
    chk("busy_wr_err", a_wr_err, 1); chk("busy_rd_err0", a_err0, 1);
    step(0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    ca += int'(a_busy); cb += int'(b_busy);
    chk("busy_inv_err", a_wr_err, 1);
    for (int i = 0; i < 20 && (a_busy || b_busy); i++) begin
      idle();
      ca += int'(a_busy); cb += int'(b_busy);
    end
    chk("busy_cycles_a", ca, 8);
    chk("busy_cycles_b", cb, 6);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 3'(i), 1, 3'(i));
      chk($sformatf("postflush_err0_%0d", i), a_err0, 1);
      chk($sformatf("postflush_dout0_%0d", i), a_dout0, 0);
    end

    // Reset in the middle of a sweep.
    step(1, 5, 8'h55, 0, 0, 0, 0, 0, 0, 0);
    step(1, 6, 8'h66, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    idle();
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_busy_a", a_busy, 0);
    chk("midrst_busy_b", b_busy, 0);
    @(negedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 3'(i), 0, 0);
      chk($sformatf("postrst_err0_%0d", i), a_err0, 1);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flop_regfile_2r1w.md
Name: flop_regfile_2r1w

Overview:
Parametrised flip-flop register file with one write port and two independent read ports. Tracks per-entry valid bits and supports single-entry invalidate and a sequenced whole-array flush. Read data is registered, so each read returns one cycle after the request. Per-port error flags replace the single combinational error flag. Used as a small tag/config store beside datapath pipelines.

Parameters:
DATA_W, 8, data width in bits
ADDR_W, 3, address width
DATA_N, 8, number of entries; legal range 2..2**ADDR_W
BYPASS, 1, 1 = a read of the entry being written in the same cycle returns the new data; 0 = it returns the old contents

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
wr  in  1  write request
waddr  in  ADDR_W  write address
din  in  DATA_W  write data
inv  in  1  invalidate request for a single entry
iaddr  in  ADDR_W  invalidate address
flush  in  1  pulse that starts a sweep invalidating all entries
rd0  in  1  read request, port 0
raddr0  in  ADDR_W  read address, port 0
rd1  in  1  read request, port 1
raddr1  in  ADDR_W  read address, port 1
dout0  out  DATA_W  read data, port 0, registered
dout_v0  out  1  dout0 valid, one cycle after rd0
err0  out  1  read error, port 0, aligned with dout_v0
dout1  out  DATA_W  read data, port 1
dout_v1  out  1  dout1 valid
err1  out  1  read error, port 1
wr_err  out  1  write or invalidate dropped, registered
busy  out  1  flush sweep in progress

Behaviour:
- Reset (resetn=0, asynchronous): valid[] cleared; FSM forced to IDLE; sweep counter set to 0. All outputs are 0. The data array is not reset.
- Write: on a clock edge with wr=1, busy=0 and waddr<DATA_N, din is stored at data[waddr] and valid[waddr] is set.
- Write when waddr>=DATA_N or busy=1: the write is dropped and wr_err=1 on the next cycle.
- Invalidate: on a clock edge with inv=1, busy=0 and iaddr<DATA_N, valid[iaddr] is cleared.
- Invalidate when iaddr>=DATA_N or busy=1: the invalidate is dropped and wr_err=1.
- Write and invalidate to the same address in the same cycle: the write wins and the entry ends valid.
- Read port p (independent, identical for p=0,1): when rdp=1 at edge N, at edge N+1 doutp_v=1.
  - Good read: address <DATA_N, entry valid, busy=0. doutp = data and errp=0.
  - Bad read: address >=DATA_N, entry invalid, or busy=1. doutp = 0 and errp=1.
  - When rdp=0: doutp_v=0, errp=0, doutp=0.
- Read-during-write to the same address, BYPASS=1: the read returns din and is valid.
- Read-during-write to the same address, BYPASS=0: the read returns the pre-write data; if the entry was previously invalid, the read is an error.
- Read-during-invalidate to the same address: the read sees the pre-invalidate state.
- Both ports reading the same address: legal, and both ports return identical results.
- Flush FSM:
  - IDLE: flush=1 moves the FSM to SWEEP with counter=0 and busy=1 from the next cycle.
  - SWEEP: each cycle clears valid[counter] and increments the counter. When counter=DATA_N-1 the FSM returns to IDLE and busy drops on the following cycle.
  - The sweep takes exactly DATA_N busy cycles.
  - flush while busy is ignored and does not raise an error.
  - flush takes priority over a write in the same cycle; that write is accepted, then cleared by the sweep.
- Reset asserted mid-sweep: the FSM goes immediately to IDLE with busy=0 and all valid bits cleared.
- wr_err is a one-cycle pulse per dropped request. It is the OR of the write-drop and invalidate-drop conditions.

Test Plan:
- Reset, then read addr 3 on both ports -> next cycle dout_v0=dout_v1=1, err0=err1=1, dout0=dout1=0.
- Write 0xA5 to addr 2, then read addr 2 on port 0 and addr 5 on port 1 in the same cycle -> dout0=0xA5 with err0=0; err1=1 with dout1=0.
- BYPASS=1: write 0x3C to addr 4 while rd0 reads addr 4 -> dout0=0x3C, err0=0. BYPASS=0, same stimulus on a fresh entry -> err0=1, dout0=0.
- DATA_N=6, ADDR_W=3: write to addr 7 -> wr_err=1 next cycle, and a later read of addr 7 -> err=1.
- Fill all 8 entries, pulse flush -> busy high for exactly 8 cycles; a write issued during busy -> wr_err=1; all reads after busy falls -> err=1.
- Write addr 1 and invalidate addr 1 in the same cycle -> a later read of addr 1 returns din with err=0. Assert resetn at sweep cycle 3 -> busy=0 immediately and no entries remain valid.
